// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative RISC-V M-extension engine behind valid/ready handshakes.
// Base ops complete in one registered cycle; MUL/DIV/REM take XLEN shift-add or restoring-divide steps.
module alu_mdu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
  logic [2:0]        mop_q, mop_d;
  logic              sa_q, sa_d, neg_q, neg_d;

  logic              accept, is_mop, is_div, last_step, sa, sb;
  logic [XLEN-1:0]   base_res, ma, mb, hi_n, lo_n, quo_s, rem_s, final_res;
  logic [XLEN:0]     mul_sum, div_rt, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod, prod_s;

  assign is_mop    = op[4] & ~op[3];
  assign is_div    = op[2];
  assign accept    = in_valid & in_ready & ~flush;
  assign last_step = (cnt_q == CW'(1));
  assign result    = result_q;

  // Single-cycle base operations; unused encodings yield zero.
  always_comb begin
    base_res = '0;
    case (op)
      5'b00000: base_res = a + b;
      5'b00001: base_res = a ^ b;
      5'b00010: base_res = a | b;
      5'b00011: base_res = a & b;
      5'b00100: base_res = a << b[SHW-1:0];
      5'b00101: base_res = a >> b[SHW-1:0];
      5'b00110: base_res = XLEN'($signed(a) >>> b[SHW-1:0]);
      5'b00111: base_res = XLEN'($signed(a) < $signed(b));
      5'b01000: base_res = XLEN'(a < b);
      5'b01001: base_res = a - b;
      default:  base_res = '0;
    endcase
  end

  // Operand signs and magnitudes for the iterative engine.
  always_comb begin
    sa = a[XLEN-1] & (is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10));
    sb = b[XLEN-1] & (is_div ? ~op[0] : (op[1:0] == 2'b01));
    ma = sa ? -a : a;
    mb = sb ? -b : b;
  end

  // One engine step: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rt   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_rt - {1'b0, opnd_q};
    div_ge   = ~div_diff[XLEN];
    if (mop_q[2]) begin
      hi_n = div_ge ? div_diff[XLEN-1:0] : div_rt[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_n : lo_n;
    rem_s  = sa_q ? -hi_n : hi_n;
    case (mop_q)
      3'b000:          final_res = prod_s[XLEN-1:0];
      3'b100, 3'b101:  final_res = quo_s;
      3'b110, 3'b111:  final_res = rem_s;
      default:         final_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = is_mop ? S_BUSY : S_DONE;
      S_BUSY:  if (last_step) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = accept ? (is_mop ? S_BUSY : S_DONE) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    out_valid = (state_q == S_DONE);
  end

  // Datapath next state; a divisor of zero keeps the all-ones quotient unsigned.
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    mop_d    = mop_q;
    sa_d     = sa_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (flush) begin
      cnt_d    = '0;
      result_d = '0;
    end else if (accept) begin
      if (is_mop) begin
        hi_d   = '0;
        lo_d   = is_div ? ma : mb;
        opnd_d = is_div ? mb : ma;
        cnt_d  = CW'(XLEN);
        mop_d  = op[2:0];
        sa_d   = sa;
        neg_d  = is_div ? ((sa ^ sb) & (b != '0)) : (sa ^ sb);
      end else begin
        result_d = base_res;
      end
    end else if (state_q == S_BUSY) begin
      hi_d  = hi_n;
      lo_d  = lo_n;
      cnt_d = cnt_q - CW'(1);
      if (last_step) result_d = final_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      mop_q    <= '0;
      sa_q     <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      mop_q    <= mop_d;
      sa_q     <= sa_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: stimulus pushes expected results and arrival cycles, a monitor pops them.
module tb_alu_mdu;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd9,  OP_SLT = 5'd7, OP_SLTU = 5'd8;
  localparam logic [4:0] OP_SRA = 5'd6,  OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU = 5'd19, OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22;
  localparam logic [4:0] OP_REMU = 5'd23;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic [4:0]      op = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   stalls = 0;
  bit   bp_mode = 1'b0;
  bit   ready_force = 1'b1;

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model written straight from the RISC-V arithmetic rules.
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    logic signed [63:0] p;
    logic [63:0]        pu;
    int                 sh;
    sx = x;
    sy = y;
    sh = int'(y[4:0]);
    case (o)
      5'd0:  return x + y;
      5'd1:  return x ^ y;
      5'd2:  return x | y;
      5'd3:  return x & y;
      5'd4:  return x << sh;
      5'd5:  return x >> sh;
      5'd6:  return 32'(sx >>> sh);
      5'd7:  return (sx < sy) ? 32'd1 : 32'd0;
      5'd8:  return (x < y) ? 32'd1 : 32'd0;
      5'd9:  return x - y;
      5'd16, 5'd17: begin
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return (o == 5'd16) ? p[31:0] : p[63:32];
      end
      5'd18: begin
        p = $signed({{32{x[31]}}, x}) * $signed({32'b0, y});
        return p[63:32];
      end
      5'd19: begin
        pu = {32'b0, x} * {32'b0, y};
        return pu[63:32];
      end
      5'd20: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'(sx / sy);
      end
      5'd21: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd22: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sx % sy);
      end
      5'd23: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat(input logic [4:0] o);
    return (o[4:3] == 2'b10) ? 33 : 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the edge that took the request.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      n++;
      if (n > 500) begin
        chk(1'b0, "accept_timeout", 32'(n), 32'd500);
        break;
      end
    end
    if (in_ready) sb_q.push_back('{res: e, due: cyc + lat(o)});
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk(1'b0, "drain_timeout", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_checks(input string tag);
    @(negedge clk);
    chk(out_valid == 1'b0, {tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk(in_ready == 1'b1, {tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk(result == '0, {tag, "_result"}, result, 32'd0);
  endtask

  // Owns out_ready: forced level or random backpressure, updated just after each rising edge.
  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Checks arrival cycle on first presentation, value on every valid cycle, pops on handshake.
  initial begin : monitor
    bit   first_seen;
    exp_t e;
    first_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!out_valid) begin
        first_seen = 1'b0;
      end else if (sb_q.size() == 0) begin
        chk(1'b0, "unexpected_valid", result, 32'd0);
      end else begin
        e = sb_q[0];
        if (!first_seen) begin
          chk(cyc == e.due, "latency", 32'(cyc), 32'(e.due));
          first_seen = 1'b1;
        end
        chk(result == e.res, "result", result, e.res);
        if (out_ready) begin
          void'(sb_q.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    int s0;
    logic [4:0] ro;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    idle_checks("reset");
    @(posedge clk);
    #2;

    issue(OP_ADD,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000);
    issue(OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000);
    issue(OP_SRA,  32'h8000_0000, 32'h24,        32'hF800_0000);
    issue(OP_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF);
    issue(5'd10,   32'h1234_5678, 32'h1,         32'h0000_0000);
    issue(5'd24,   32'h1234_5678, 32'h1,         32'h0000_0000);
    issue(OP_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(OP_MUL,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    issue(OP_DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF);
    issue(OP_REMU, 32'd7,         32'd0,         32'h0000_0007);
    issue(OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    issue(OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    drain();

    s0 = stalls;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      issue(OP_ADD, ra, rb, ra + rb);
    end
    chk(stalls == s0, "b2b_in_ready_drops", 32'(stalls - s0), 32'd0);
    drain();

    // Result held under backpressure; a held request is taken together with the release.
    @(negedge clk);
    ready_force = 1'b0;
    @(posedge clk);
    #2;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14);
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    in_valid = 1'b1;
    op = OP_ADD;
    a = 32'd5;
    b = 32'd6;
    for (int i = 0; i < 5; i++) begin
      chk(in_ready == 1'b0, "bp_in_ready", 32'(in_ready), 32'd0);
      if (i == 4) ready_force = 1'b1;
      @(negedge clk);
    end
    chk(in_ready == 1'b1, "bp_release_in_ready", 32'(in_ready), 32'd1);
    if (in_ready) sb_q.push_back('{res: 32'd11, due: cyc + 1});
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    drain();

    // Flush part-way through a multiply.
    issue(OP_MUL, 32'h0001_0003, 32'h0007_0005, 32'hDEAD_BEEF);
    repeat (9) @(posedge clk);
    #2;
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    sb_q.delete();
    idle_checks("flush_busy");

    // A request in the flush cycle is dropped.
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    op = OP_ADD;
    a = 32'd1;
    b = 32'd2;
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    in_valid = 1'b0;
    idle_checks("flush_req");

    // Reset while a result waits under backpressure.
    ready_force = 1'b0;
    @(posedge clk);
    #2;
    issue(OP_ADD, 32'd40, 32'd2, 32'd42);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb_q.delete();
    idle_checks("rst_done");
    ready_force = 1'b1;
    @(posedge clk);
    #2;
    issue(OP_MUL, 32'd3, 32'd5, 32'd15);
    drain();

    // Randomized operations under random backpressure.
    @(negedge clk);
    bp_mode = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 80; i++) begin
      ro = 5'($urandom_range(0, 31));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb, model(ro, ra, rb));
    end
    @(negedge clk);
    bp_mode = 1'b0;
    drain();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=%0d required=finish", cyc);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor of the single-cycle RV32I ALU: width-generic datapath covering the base ALU ops plus the RISC-V M-extension multiply/divide/remainder ops.
- Base ops finish in one registered cycle. M ops run on an iterative engine.
- Sits in the execute stage. Input and output use valid/ready handshakes so the pipeline can stall on long ops.

Parameters:
- XLEN, 32, operand/result width in bits (power of two, ≥ 8).
- SHW, $clog2(XLEN), shift-amount width; only b[SHW-1:0] is used for shifts.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort of any in-flight op; result discarded
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2/imm)
- op  in  5  operation code
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result, held stable while out_valid && !out_ready

Behaviour:
- Op codes, op[4]=0 (base ops):
  - 00000 ADD, 00001 XOR, 00010 OR, 00011 AND
  - 00100 SLL, 00101 SRL, 00110 SRA (sign-filling)
  - 00111 SLT signed, 01000 SLTU, 01001 SUB
  - 01010–01111: result 0
- Op codes, op[4]=1 (M ops):
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU
  - 11000–11111: result 0, base-op latency
- SLT/SLTU produce 1 or 0, zero-extended to XLEN. Add/sub wrap mod 2^XLEN.
- MUL returns the low XLEN bits of the 2·XLEN product. MULH/MULHSU/MULHU return the high XLEN bits: signed×signed, signed×unsigned, unsigned×unsigned.
- DIV/DIVU truncate toward zero. REM takes the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = a.
- Signed overflow (a = -2^(XLEN-1), b = -1): DIV returns a, REM returns 0.
- States and transitions:
  - IDLE: in_ready=1. On a handshake (in_valid && in_ready) with a base/illegal op: latch the result, go to DONE. With an M op: latch operands, go to BUSY with counter = XLEN.
  - BUSY: in_ready=0. One shift-add or restoring-divide step per cycle; counter decrements. Counter reaching 0 means the final step is this cycle: write result, go to DONE.
  - DONE: out_valid=1, in_ready=out_ready. On out_ready: a simultaneous new request is accepted (same decode as IDLE); otherwise go to IDLE. On !out_ready: hold result and state.
- Latency from handshake cycle T:
  - base ops: out_valid at T+1
  - M ops, including div-by-zero and overflow: out_valid at T+XLEN+1
  - sustained throughput of base ops with out_ready=1: 1 per cycle
- Sign handling: operate on magnitudes; apply sign correction in the final step.
- Reset values: state IDLE, out_valid=0, in_ready=1 in the cycle after rst, result=0, counter=0.
- rst or flush in any state, including mid-BUSY and DONE-under-backpressure: next cycle is IDLE, out_valid=0, result cleared to 0. rst has priority over flush. A request presented in the same cycle as flush is dropped.
- in_valid while BUSY is ignored and not queued; the requester must hold it.

Test Plan:
- ADD a=0xFFFFFFFF b=1 → result 0x00000000 at T+1; SLT a=0xFFFFFFFF b=1 → 1; SLTU same operands → 0; SRA a=0x80000000 b=0x24 (shift 4) → 0xF8000000.
- Back-to-back base ops: 8 consecutive ADDs with out_ready=1 → 8 results on 8 consecutive cycles, in_ready never drops.
- MULH a=0x80000000 b=0xFFFFFFFF → 0x00000000 and MUL → 0x80000000, each at T+33; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; DIVU 7/0 → 0xFFFFFFFF, REMU 7/0 → 7; REM -7/2 → 0xFFFFFFFF; all at T+33.
- Backpressure: DIVU completes with out_ready=0 for 5 cycles → result stable, in_ready=0, no new accept; out_ready=1 with in_valid ADD in the same cycle → ADD accepted, its result appears next cycle.
- Flush at BUSY cycle 10, and rst asserted in DONE → IDLE next cycle, out_valid=0, result=0; a following MUL 3×5 → 15 at T+33.
